// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among num_req_p requesters; response routing via an ID FIFO.
// Optional per-requester grant counters enabled by defining BP_ME_MEM_ARB_GRANT_CNT_EN.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 512,
  parameter int max_outst_p = 4,
  parameter int cnt_width_p = 32
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0]   req_cmd_i,
  input  logic [num_req_p-1:0]               req_cmd_v_i,
  output logic [num_req_p-1:0]               req_cmd_ready_o,
  output logic [num_req_p*msg_width_p-1:0]   req_resp_o,
  output logic [num_req_p-1:0]               req_resp_v_o,
  input  logic [num_req_p-1:0]               req_resp_yumi_i,
  output logic [msg_width_p-1:0]             mem_cmd_o,
  output logic                               mem_cmd_v_o,
  input  logic                               mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]             mem_resp_i,
  input  logic                               mem_resp_v_i,
  output logic                               mem_resp_yumi_o,
  output logic [$clog2(max_outst_p+1)-1:0]   outst_cnt_o,
  output logic                               err_o,
  output logic [num_req_p*cnt_width_p-1:0]   grant_cnt_o
);

  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int ptr_w_lp  = (max_outst_p > 1) ? $clog2(max_outst_p) : 1;
  localparam int cnt_w_lp  = $clog2(max_outst_p+1);

  localparam logic [cnt_w_lp-1:0]  full_cnt_lp = cnt_w_lp'(max_outst_p);
  localparam logic [ptr_w_lp-1:0]  last_ptr_lp = ptr_w_lp'(max_outst_p-1);
  localparam logic [lg_req_lp-1:0] last_req_lp = lg_req_lp'(num_req_p-1);

  logic [lg_req_lp-1:0] rr_ptr_reg, rr_ptr_next;
  logic [lg_req_lp-1:0] win;
  logic                 any_v;
  logic                 fifo_full, fifo_empty;
  logic                 cmd_hs;
  logic                 resp_valid;
  logic                 deq;
  logic [lg_req_lp-1:0] resp_head;

  logic [lg_req_lp-1:0] route_mem_reg [0:max_outst_p-1];
  logic [ptr_w_lp-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [cnt_w_lp-1:0]  outst_reg;
  logic                 err_reg;

  assign any_v      = |req_cmd_v_i;
  assign fifo_full  = (outst_reg == full_cnt_lp);
  assign fifo_empty = (outst_reg == '0);

  // Scan from highest offset down so the requester closest to rr_ptr wins last.
  always_comb begin
    int                   idx;
    logic [lg_req_lp-1:0] idx_l;
    idx   = 0;
    idx_l = '0;
    win   = rr_ptr_reg;
    for (int k = num_req_p-1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      idx_l = lg_req_lp'(idx);
      if (req_cmd_v_i[idx_l]) win = idx_l;
    end
  end

  always_comb begin
    mem_cmd_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (win == lg_req_lp'(i)) mem_cmd_o = req_cmd_i[i*msg_width_p +: msg_width_p];
    end
  end

  assign rr_ptr_next = (win == last_req_lp) ? '0 : win + 1'b1;

  assign mem_cmd_v_o = reset_n_i & any_v & ~fifo_full;
  assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_i;

  assign resp_head       = route_mem_reg[rd_ptr_reg];
  assign resp_valid      = reset_n_i & mem_resp_v_i & ~fifo_empty;
  assign mem_resp_yumi_o = resp_valid & req_resp_yumi_i[resp_head];
  assign deq             = mem_resp_yumi_o;

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_port
    assign req_cmd_ready_o[gi] = reset_n_i & mem_cmd_ready_i & ~fifo_full
                                 & (win == lg_req_lp'(gi));
    assign req_resp_v_o[gi]    = resp_valid & (resp_head == lg_req_lp'(gi));
    assign req_resp_o[gi*msg_width_p +: msg_width_p] = mem_resp_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      outst_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (cmd_hs) begin
        rr_ptr_reg <= rr_ptr_next;
        wr_ptr_reg <= (wr_ptr_reg == last_ptr_lp) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (deq) begin
        rd_ptr_reg <= (rd_ptr_reg == last_ptr_lp) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({cmd_hs, deq})
        2'b10:   outst_reg <= outst_reg + 1'b1;
        2'b01:   outst_reg <= outst_reg - 1'b1;
        default: outst_reg <= outst_reg;
      endcase
      // A response with nothing outstanding has no owner; flag it until reset.
      if (mem_resp_v_i && fifo_empty) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_hs) route_mem_reg[wr_ptr_reg] <= win;
  end

  assign outst_cnt_o = outst_reg;
  assign err_o       = err_reg;

`ifdef BP_ME_MEM_ARB_GRANT_CNT_EN
  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_cnt
    logic [cnt_width_p-1:0] cnt_reg;
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        cnt_reg <= '0;
      end else if (cmd_hs && (win == lg_req_lp'(gi)) && !(&cnt_reg)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign grant_cnt_o[gi*cnt_width_p +: cnt_width_p] = cnt_reg;
  end
`else
  assign grant_cnt_o = '0;
`endif

  // A requester must only consume a response that is being offered.
  yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (|req_resp_yumi_i) |-> (|req_resp_v_o));

endmodule
